// File: rtl/nn_mul_pipe_fx_pkg.sv
// Shared constants and helpers for the pipelined fixed-point NN multiplier.
package nn_mul_pkg;

  localparam int NUM_STAGE_MIN  = 1;
  localparam int NUM_STAGE_MAX  = 6;
  localparam int FRAC_SHIFT_MIN = 0;
  // Working width for the rounded result; covers the largest product (131 bits)
  // plus the rounding carry and the widest output range with margin.
  localparam int SAT_W = 256;

  function automatic int prod_width(input int w0, input int w1);
    return w0 + w1 + 1;
  endfunction

  function automatic int frac_shift_max(input int w0, input int w1);
    return w0 + w1 - 1;
  endfunction

  // Representable range of a dw-bit result, two's complement or unsigned.
  function automatic void sat_bounds(input int dw, input logic is_signed,
                                     output logic signed [SAT_W-1:0] lo,
                                     output logic signed [SAT_W-1:0] hi);
    logic signed [SAT_W-1:0] one;
    one = SAT_W'(1);
    if (is_signed) begin
      hi = (one <<< (dw - 1)) - one;
      lo = -(one <<< (dw - 1));
    end else begin
      hi = (one <<< dw) - one;
      lo = '0;
    end
  endfunction

endpackage

// File: rtl/nn_mul_pipe_fx_if.sv
// Operand/result stream bundle with valid/ready on both sides.
interface nn_mul_pipe_fx_if #(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  din0_signed;
  logic                  din1_signed;
  logic                  out_valid;
  logic                  out_ready;
  logic [dout_WIDTH-1:0] dout;
  logic                  dout_ovf;

  modport master (
    output in_valid, din0, din1, din0_signed, din1_signed, out_ready,
    input  in_ready, out_valid, dout, dout_ovf
  );

  modport slave (
    input  in_valid, din0, din1, din0_signed, din1_signed, out_ready,
    output in_ready, out_valid, dout, dout_ovf
  );
endinterface

// File: rtl/nn_mul_pipe_fx_round_sat.sv
// Round-half-up rescale of the full product, then clamp or truncate to dout.
module nn_mul_round_sat
  import nn_mul_pkg::*;
#(
  parameter int P          = 33,
  parameter int dout_WIDTH = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int SATURATE   = 1
) (
  input  logic signed [P-1:0]   prod,
  input  logic                  res_signed,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  logic signed [SAT_W-1:0] wide;
  logic signed [SAT_W-1:0] rnd;
  logic signed [SAT_W-1:0] shifted;
  logic signed [SAT_W-1:0] lo;
  logic signed [SAT_W-1:0] hi;
  logic signed [SAT_W-1:0] back;

  // rnd is half an LSB of the shifted result, and zero when there is no shift
  always_comb begin
    wide    = SAT_W'(prod);
    rnd     = (SAT_W'(1) <<< FRAC_SHIFT) >>> 1;
    shifted = (wide + rnd) >>> FRAC_SHIFT;
    sat_bounds(dout_WIDTH, res_signed, lo, hi);
    dout = shifted[dout_WIDTH-1:0];
    ovf  = 1'b0;
    back = '0;
    if (SATURATE != 0) begin
      if (shifted > hi) begin
        dout = hi[dout_WIDTH-1:0];
        ovf  = 1'b1;
      end else if (shifted < lo) begin
        dout = lo[dout_WIDTH-1:0];
        ovf  = 1'b1;
      end
    end else begin
      back = res_signed ? SAT_W'(signed'(shifted[dout_WIDTH-1:0]))
                        : SAT_W'(shifted[dout_WIDTH-1:0]);
      ovf  = (back != shifted);
    end
  end

endmodule

// File: rtl/nn_mul_pipe_fx.sv
// Pipelined fixed-point multiplier with bubble-collapsing valid/ready stages.
// Stage 0 holds operands, middle stages carry the product, last stage holds
// the rounded/saturated result.
module nn_mul_pipe_fx
  import nn_mul_pkg::*;
#(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 16,
  parameter int NUM_STAGE  = 3,
  parameter int FRAC_SHIFT = 8,
  parameter int SATURATE   = 1
) (
  input logic             clk,
  input logic             reset,
  input logic             ce,
  nn_mul_pipe_fx_if.slave bus
);

  localparam int P      = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int NS_EFF = (NUM_STAGE < NUM_STAGE_MIN) ? NUM_STAGE_MIN :
                          (NUM_STAGE > NUM_STAGE_MAX) ? NUM_STAGE_MAX : NUM_STAGE;
  localparam int FS_MAX = frac_shift_max(din0_WIDTH, din1_WIDTH);
  localparam int FS_EFF = (FRAC_SHIFT < FRAC_SHIFT_MIN) ? FRAC_SHIFT_MIN :
                          (FRAC_SHIFT > FS_MAX) ? FS_MAX : FRAC_SHIFT;

  logic [NS_EFF-1:0]     v_q, v_d, adv, load;
  logic [NS_EFF:0]       free;
  logic [din0_WIDTH:0]   a_ext;
  logic [din1_WIDTH:0]   b_ext;
  logic                  sgn_in;
  logic signed [P-1:0]   rs_prod;
  logic                  rs_sgn;
  logic [dout_WIDTH-1:0] rs_dout, dout_q, dout_d;
  logic                  rs_ovf, ovf_q, ovf_d;

  // Extended operands always fit a P-bit signed product, so truncation is exact.
  function automatic logic signed [P-1:0] mul_ext(input logic [din0_WIDTH:0] a,
                                                  input logic [din1_WIDTH:0] b);
    logic signed [P-1:0] ap, bp;
    ap = P'(signed'(a));
    bp = P'(signed'(b));
    return ap * bp;
  endfunction

  // Extend each operand by one bit according to its own signedness
  always_comb begin
    a_ext  = {bus.din0_signed & bus.din0[din0_WIDTH-1], bus.din0};
    b_ext  = {bus.din1_signed & bus.din1[din1_WIDTH-1], bus.din1};
    sgn_in = bus.din0_signed | bus.din1_signed;
  end

  // Ready ripples backwards from the output; a stage is free if empty or draining
  always_comb begin
    free = '0;
    adv  = '0;
    load = '0;
    v_d  = '0;
    free[NS_EFF] = bus.out_ready;
    for (int k = NS_EFF - 1; k >= 0; k--) begin
      adv[k]  = ce & v_q[k] & free[k+1];
      free[k] = ~v_q[k] | adv[k];
    end
    load[0] = ce & free[0] & bus.in_valid;
    for (int k = 1; k < NS_EFF; k++) begin
      load[k] = adv[k-1];
    end
    for (int k = 0; k < NS_EFF; k++) begin
      v_d[k] = load[k] | (v_q[k] & ~adv[k]);
    end
  end

  if (NS_EFF == 1) begin : g_comb
    // Single register: whole datapath feeds the output flop directly
    always_comb begin
      rs_prod = mul_ext(a_ext, b_ext);
      rs_sgn  = sgn_in;
    end
  end else begin : g_op
    logic [din0_WIDTH:0] opa_q, opa_d;
    logic [din1_WIDTH:0] opb_q, opb_d;
    logic                sgn0_q, sgn0_d;

    // Capture operands on an accepted transfer
    always_comb begin
      opa_d  = opa_q;
      opb_d  = opb_q;
      sgn0_d = sgn0_q;
      if (load[0]) begin
        opa_d  = a_ext;
        opb_d  = b_ext;
        sgn0_d = sgn_in;
      end
    end

    // Operand stage registers
    always_ff @(posedge clk) begin
      if (reset) begin
        opa_q  <= '0;
        opb_q  <= '0;
        sgn0_q <= 1'b0;
      end else begin
        opa_q  <= opa_d;
        opb_q  <= opb_d;
        sgn0_q <= sgn0_d;
      end
    end

    if (NS_EFF == 2) begin : g_two
      // Multiply and round share the path into the output flop
      always_comb begin
        rs_prod = mul_ext(opa_q, opb_q);
        rs_sgn  = sgn0_q;
      end
    end else begin : g_mid
      localparam int NMID = NS_EFF - 2;
      logic signed [P-1:0] prod_q [NMID];
      logic signed [P-1:0] prod_d [NMID];
      logic [NMID-1:0]     msgn_q, msgn_d;

      // First middle stage multiplies; later ones just carry the product
      always_comb begin
        for (int i = 0; i < NMID; i++) begin
          prod_d[i] = prod_q[i];
        end
        msgn_d = msgn_q;
        if (load[1]) begin
          prod_d[0] = mul_ext(opa_q, opb_q);
          msgn_d[0] = sgn0_q;
        end
        for (int i = 1; i < NMID; i++) begin
          if (load[i+1]) begin
            prod_d[i] = prod_q[i-1];
            msgn_d[i] = msgn_q[i-1];
          end
        end
      end

      // Middle stage registers
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < NMID; i++) begin
            prod_q[i] <= '0;
          end
          msgn_q <= '0;
        end else begin
          for (int i = 0; i < NMID; i++) begin
            prod_q[i] <= prod_d[i];
          end
          msgn_q <= msgn_d;
        end
      end

      // Last middle stage feeds the rounding logic
      always_comb begin
        rs_prod = prod_q[NMID-1];
        rs_sgn  = msgn_q[NMID-1];
      end
    end
  end

  nn_mul_round_sat #(
    .P          (P),
    .dout_WIDTH (dout_WIDTH),
    .FRAC_SHIFT (FS_EFF),
    .SATURATE   (SATURATE)
  ) u_round_sat (
    .prod       (rs_prod),
    .res_signed (rs_sgn),
    .dout       (rs_dout),
    .ovf        (rs_ovf)
  );

  // Output stage only loads when free, so a stalled result holds still
  always_comb begin
    dout_d = dout_q;
    ovf_d  = ovf_q;
    if (load[NS_EFF-1]) begin
      dout_d = rs_dout;
      ovf_d  = rs_ovf;
    end
  end

  // Valid chain and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q    <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      v_q    <= v_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.in_ready  = ce & free[0];
  assign bus.out_valid = v_q[NS_EFF-1];
  assign bus.dout      = dout_q;
  assign bus.dout_ovf  = ovf_q;

endmodule

// File: tb/tb_nn_mul_pipe_fx.sv
// Self-checking bench for nn_mul_pipe_fx (16/16/16, 3 stages, shift 8, saturating).
module tb_nn_mul_pipe_fx;
  localparam int W0 = 16;
  localparam int W1 = 16;
  localparam int WO = 16;
  localparam int NS = 3;
  localparam int FS = 8;

  typedef struct packed {
    logic [WO-1:0] d;
    logic          o;
  } res_t;

  typedef struct packed {
    logic [W0-1:0] a;
    logic [W1-1:0] b;
    logic          sa;
    logic          sb;
    logic [WO-1:0] d;
    logic          o;
  } vec_t;

  logic clk;
  logic reset;
  logic ce;
  int   total;
  int   bad;
  res_t exp_q[$];
  logic [W0-1:0] bp_a  [6];
  logic [W1-1:0] bp_b  [6];
  logic          bp_sa [6];
  logic          bp_sb [6];

  nn_mul_pipe_fx_if #(.din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WO)) bus ();

  nn_mul_pipe_fx #(
    .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WO),
    .NUM_STAGE(NS), .FRAC_SHIFT(FS), .SATURATE(1)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer product, round half up, clamp to output range.
  function automatic res_t model(input logic [W0-1:0] a, input logic [W1-1:0] b,
                                 input logic sa, input logic sb);
    longint av, bv, p, lo, hi;
    res_t r;
    av = sa ? longint'(signed'(a)) : longint'(a);
    bv = sb ? longint'(signed'(b)) : longint'(b);
    p  = av * bv;
    p  = (p + (longint'(1) <<< (FS - 1))) >>> FS;
    if (sa || sb) begin
      hi = (longint'(1) <<< (WO - 1)) - 1;
      lo = -(longint'(1) <<< (WO - 1));
    end else begin
      hi = (longint'(1) <<< WO) - 1;
      lo = 0;
    end
    r.o = 1'b0;
    if (p > hi) begin
      p = hi; r.o = 1'b1;
    end else if (p < lo) begin
      p = lo; r.o = 1'b1;
    end
    r.d = p[WO-1:0];
    return r;
  endfunction

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 9))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      5: return 16'h0080;
      default: return 16'($urandom());
    endcase
  endfunction

  // Drive one cycle, sample mid-cycle, return what happens on the next edge.
  task automatic step(input logic iv, input logic [W0-1:0] a, input logic [W1-1:0] b,
                      input logic sa, input logic sb, input logic ordy, input logic cev,
                      output logic acc, output logic pop, output logic ov, output logic irdy,
                      output logic [WO-1:0] d, output logic o);
    bus.in_valid    = iv;
    bus.din0        = a;
    bus.din1        = b;
    bus.din0_signed = sa;
    bus.din1_signed = sb;
    bus.out_ready   = ordy;
    ce              = cev;
    @(negedge clk);
    irdy = bus.in_ready;
    ov   = bus.out_valid;
    d    = bus.dout;
    o    = bus.dout_ovf;
    acc  = iv & irdy & cev;
    pop  = ov & ordy & cev;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic acc, pop, ov, irdy, o;
    logic [WO-1:0] d;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, acc, pop, ov, irdy, d, o);
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", ov); end
    total++; if (d !== '0) begin bad++; $display("FAIL reset_dout got=%h want=0000", d); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", o); end
    total++; if (irdy !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", irdy); end
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc, pop, ov, irdy, d, o);
    total++; if (irdy !== 1'b0) begin bad++; $display("FAIL ce0_in_ready got=%0b want=0", irdy); end
  endtask

  task automatic test_arith();
    vec_t vecs[10];
    logic acc, pop, ov, irdy, o;
    logic [WO-1:0] d;
    int lat;
    vecs[0] = '{16'h0180, 16'h0200, 1'b1, 1'b1, 16'h0300, 1'b0};
    vecs[1] = '{16'hFF00, 16'h0180, 1'b1, 1'b1, 16'hFE80, 1'b0};
    vecs[2] = '{16'hFF00, 16'h0180, 1'b0, 1'b0, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h7F00, 16'h7F00, 1'b1, 1'b1, 16'h7FFF, 1'b1};
    vecs[4] = '{16'h8000, 16'h7F00, 1'b1, 1'b1, 16'h8000, 1'b1};
    vecs[5] = '{16'h0001, 16'h0080, 1'b1, 1'b1, 16'h0001, 1'b0};
    vecs[6] = '{16'h0001, 16'h007F, 1'b1, 1'b1, 16'h0000, 1'b0};
    vecs[7] = '{16'hFFFF, 16'h0100, 1'b1, 1'b0, 16'hFFFF, 1'b0};
    vecs[8] = '{16'hFFFF, 16'h0080, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[9] = '{16'hFFFF, 16'h0081, 1'b1, 1'b0, 16'hFFFF, 1'b0};
    for (int i = 0; i < 10; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, 1'b1, 1'b1, acc, pop, ov, irdy, d, o);
      total++; if (acc !== 1'b1) begin bad++; $display("FAIL arith_accept vec=%0d got=%0b want=1", i, acc); end
      lat = 0;
      pop = 1'b0;
      while (!pop && lat < 10) begin
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, acc, pop, ov, irdy, d, o);
        lat++;
      end
      total++; if (lat !== NS) begin bad++; $display("FAIL arith_latency vec=%0d got=%0d want=%0d", i, lat, NS); end
      total++; if (d !== vecs[i].d) begin bad++; $display("FAIL arith_dout vec=%0d got=%h want=%h", i, d, vecs[i].d); end
      total++; if (o !== vecs[i].o) begin bad++; $display("FAIL arith_ovf vec=%0d got=%0b want=%0b", i, o, vecs[i].o); end
    end
  endtask

  task automatic test_back_to_back();
    logic acc, pop, ov, irdy, o;
    logic [WO-1:0] d;
    logic [W0-1:0] a;
    logic [W1-1:0] b;
    logic sa, sb;
    int pushed, popped, first_pop, last_pop;
    res_t e;
    pushed = 0; popped = 0; first_pop = -1; last_pop = -1;
    exp_q.delete();
    for (int c = 0; c < 40 && popped < 12; c++) begin
      a = rand_op(); b = rand_op(); sa = 1'($urandom()); sb = 1'($urandom());
      step(pushed < 12, a, b, sa, sb, 1'b1, 1'b1, acc, pop, ov, irdy, d, o);
      total++; if (irdy !== 1'b1) begin bad++; $display("FAIL b2b_in_ready cyc=%0d got=%0b want=1", c, irdy); end
      if (acc) begin exp_q.push_back(model(a, b, sa, sb)); pushed++; end
      if (pop) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        e = exp_q.pop_front();
        total++;
        if (d !== e.d || o !== e.o) begin
          bad++; $display("FAIL b2b_result n=%0d got=%h/%0b want=%h/%0b", popped, d, o, e.d, e.o);
        end
        popped++;
      end
    end
    total++; if (first_pop !== NS) begin bad++; $display("FAIL b2b_first_pop got=%0d want=%0d", first_pop, NS); end
    total++; if (last_pop - first_pop !== 11) begin bad++; $display("FAIL b2b_throughput span got=%0d want=11", last_pop - first_pop); end
  endtask

  task automatic test_backpressure(input logic use_ce);
    logic acc, pop, ov, irdy, o, ordy, cev, prev_stall, saw_block;
    logic [WO-1:0] d, prev_d;
    int pushed, popped;
    res_t e;
    pushed = 0; popped = 0; prev_stall = 1'b0; prev_d = '0; saw_block = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 80 && popped < 6; c++) begin
      ordy = !(c >= 4 && c <= 9);
      cev  = use_ce ? ((c % 3) != 1) : 1'b1;
      step(pushed < 6, bp_a[pushed % 6], bp_b[pushed % 6], bp_sa[pushed % 6], bp_sb[pushed % 6],
           ordy, cev, acc, pop, ov, irdy, d, o);
      total++;
      if (irdy !== (cev && ((pushed - popped) < NS || ordy))) begin
        bad++; $display("FAIL bp_in_ready ce_mode=%0b cyc=%0d got=%0b occ=%0d", use_ce, c, irdy, pushed - popped);
      end
      if (pushed < 6 && !irdy) saw_block = 1'b1;
      if (prev_stall) begin
        total++;
        if (ov !== 1'b1 || d !== prev_d) begin
          bad++; $display("FAIL bp_hold cyc=%0d got=%0b/%h want=1/%h", c, ov, d, prev_d);
        end
      end
      prev_stall = ov && !(ordy && cev);
      prev_d = d;
      if (acc) begin
        exp_q.push_back(model(bp_a[pushed], bp_b[pushed], bp_sa[pushed], bp_sb[pushed]));
        pushed++;
      end
      if (pop) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL bp_extra_result got=%h want=none", d);
        end else begin
          e = exp_q.pop_front();
          if (d !== e.d || o !== e.o) begin
            bad++; $display("FAIL bp_result ce_mode=%0b n=%0d got=%h/%0b want=%h/%0b", use_ce, popped, d, o, e.d, e.o);
          end
        end
        popped++;
      end
    end
    total++; if (popped !== 6 || pushed !== 6) begin bad++; $display("FAIL bp_count got=%0d/%0d want=6/6", pushed, popped); end
    total++; if (saw_block !== 1'b1) begin bad++; $display("FAIL bp_in_ready_drop got=%0b want=1", saw_block); end
  endtask

  task automatic test_random();
    logic acc, pop, ov, irdy, o, iv, ordy, cev, sa, sb;
    logic [WO-1:0] d;
    logic [W0-1:0] a;
    logic [W1-1:0] b;
    int pushed, popped;
    res_t e;
    pushed = 0; popped = 0;
    exp_q.delete();
    for (int c = 0; c < 460; c++) begin
      iv   = (c < 400) && ($urandom_range(0, 3) != 0);
      ordy = (c >= 400) || ($urandom_range(0, 3) != 0);
      cev  = (c >= 400) || ($urandom_range(0, 9) != 0);
      a = rand_op(); b = rand_op(); sa = 1'($urandom()); sb = 1'($urandom());
      step(iv, a, b, sa, sb, ordy, cev, acc, pop, ov, irdy, d, o);
      total++;
      if (irdy !== (cev && ((pushed - popped) < NS || ordy))) begin
        bad++; $display("FAIL rnd_in_ready cyc=%0d got=%0b occ=%0d", c, irdy, pushed - popped);
      end
      if (acc) begin exp_q.push_back(model(a, b, sa, sb)); pushed++; end
      if (pop) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_extra_result got=%h want=none", d);
        end else begin
          e = exp_q.pop_front();
          if (d !== e.d || o !== e.o) begin
            bad++; $display("FAIL rnd_result n=%0d got=%h/%0b want=%h/%0b", popped, d, o, e.d, e.o);
          end
        end
        popped++;
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_drain left=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_midflight();
    logic acc, pop, ov, irdy, o;
    logic [WO-1:0] d;
    res_t e;
    int npop, lat, pop_lat;
    step(1'b1, 16'h1234, 16'h0567, 1'b1, 1'b1, 1'b0, 1'b1, acc, pop, ov, irdy, d, o);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL rst_mid_accept0 got=%0b want=1", acc); end
    step(1'b1, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, acc, pop, ov, irdy, d, o);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL rst_mid_accept1 got=%0b want=1", acc); end
    reset = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, acc, pop, ov, irdy, d, o);
    reset = 1'b0;
    e = model(16'hF123, 16'h0456, 1'b1, 1'b0);
    step(1'b1, 16'hF123, 16'h0456, 1'b1, 1'b0, 1'b1, 1'b1, acc, pop, ov, irdy, d, o);
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid got=%0b want=0", ov); end
    total++; if (d !== '0) begin bad++; $display("FAIL rst_mid_dout got=%h want=0000", d); end
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL rst_mid_accept2 got=%0b want=1", acc); end
    npop = 0; pop_lat = -1;
    for (lat = 1; lat <= 8; lat++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, acc, pop, ov, irdy, d, o);
      if (pop) begin
        npop++;
        if (pop_lat < 0) begin
          pop_lat = lat;
          total++;
          if (d !== e.d || o !== e.o) begin
            bad++; $display("FAIL rst_mid_result got=%h/%0b want=%h/%0b", d, o, e.d, e.o);
          end
        end
      end
    end
    total++; if (npop !== 1) begin bad++; $display("FAIL rst_mid_count got=%0d want=1", npop); end
    total++; if (pop_lat !== NS) begin bad++; $display("FAIL rst_mid_latency got=%0d want=%0d", pop_lat, NS); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    ce    = 1'b1;
    bus.in_valid    = 1'b0;
    bus.din0        = '0;
    bus.din1        = '0;
    bus.din0_signed = 1'b0;
    bus.din1_signed = 1'b0;
    bus.out_ready   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bp_a[i]  = rand_op();
      bp_b[i]  = rand_op();
      bp_sa[i] = 1'($urandom());
      bp_sb[i] = 1'($urandom());
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_arith();
    test_back_to_back();
    test_backpressure(1'b0);
    test_backpressure(1'b1);
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nn_mul_pipe_fx.md
Name: nn_mul_pipe_fx

Overview:
- Parametrised, pipelined fixed-point multiplier for the NN datapath. Successor to the single-cycle unsigned HLS multiplier cores.
- Adds per-transaction operand signedness, fixed-point rescale with round-half-up, optional saturation with an overflow flag, and a configurable pipeline depth.
- Valid/ready handshake with bubble-collapsing stages, so it drops directly between conv/FC accumulator streams.

Parameters:
- din0_WIDTH, 16, operand A width (2..64)
- din1_WIDTH, 16, operand B width (2..66)
- dout_WIDTH, 16, result width (2..130)
- NUM_STAGE, 3, pipeline registers from input to output (1..6)
- FRAC_SHIFT, 8, arithmetic right shift applied to the full product (0..din0_WIDTH+din1_WIDTH-1)
- SATURATE, 1, 1 = clamp to the dout range; 0 = keep low dout_WIDTH bits

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable; 0 freezes every register
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- din0  in  din0_WIDTH  operand A
- din1  in  din1_WIDTH  operand B
- din0_signed  in  1  1 = din0 is two's complement
- din1_signed  in  1  1 = din1 is two's complement
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- dout  out  dout_WIDTH  scaled result
- dout_ovf  out  1  result was clamped (SATURATE=1) or truncation lost significant bits (SATURATE=0)

Behaviour:
- Reset (sync, active-high): all stage valid bits, dout and dout_ovf cleared to 0. in_ready is 1 after reset when ce=1. Reset mid-operation discards all in-flight results; nothing is emitted for them.
- Handshake: a transfer occurs on the rising edge when valid && ready && ce. in_ready = ce && (!v[0] || stage 0 advances). Stage k advances when ce && v[k] && (!v[k+1] || stage k+1 advances). The last stage advances when out_ready.
- out_valid = v[NUM_STAGE-1]. dout and dout_ovf hold stable while out_valid && !out_ready.
- Latency: exactly NUM_STAGE cycles from accept to out_valid with no stalls. Throughput is 1 result per cycle. Bubbles collapse: a stalled output still lets upstream stages fill, so up to NUM_STAGE results are buffered. Order is preserved.
- ce=0: no state changes and in_ready=0. out_valid stays as is, but no transfer is counted.
- Arithmetic:
  - Each operand is extended by 1 bit, using its sign bit if its signed flag is set, else a 0.
  - Signed product width P = din0_WIDTH+din1_WIDTH+1.
  - If FRAC_SHIFT>0, add 2^(FRAC_SHIFT-1), then arithmetic shift right by FRAC_SHIFT (round half up).
  - res_signed = din0_signed | din1_signed. It travels with the data through the pipeline.
- Output mapping:
  - SATURATE=1, res_signed: clamp to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
  - SATURATE=1, unsigned: clamp to [0, 2^(dout_WIDTH-1... )] i.e. [0, 2^dout_WIDTH-1].
  - dout_ovf=1 whenever a clamp occurred.
  - SATURATE=0: dout = low dout_WIDTH bits. dout_ovf=1 if the discarded upper bits are not a sign/zero extension of dout.
- Stage placement:
  - Stage 0 registers the operands and flags.
  - The multiply is spread over the middle stages (retiming allowed).
  - Round/shift/saturate sits in the final stage.
  - With NUM_STAGE=1, everything runs combinationally into the single register.
- Simultaneous pop at the last stage and push at stage 0 with a full pipe: both occur, and occupancy is unchanged.

Decomposition:
- Package nn_mul_pkg:
  - function prod_width(w0,w1) returning w0+w1+1.
  - localparam-style constants for the NUM_STAGE and FRAC_SHIFT legal ranges.
  - function sat_bounds for signed and unsigned ranges.
- One sub-module nn_mul_round_sat: combinational round, shift and saturate/truncate plus ovf detection, parametrised by P, dout_WIDTH, FRAC_SHIFT and SATURATE.
- Pipeline control, valid chain and multiply stay in the top level.

Test Plan (defaults 16/16/16, NUM_STAGE=3, FRAC_SHIFT=8, SAT=1):
- 0x0180 x 0x0200, both signed -> dout=0x0300, ovf=0, out_valid exactly 3 cycles after accept.
- 0xFF00 x 0x0180, both signed -> 0xFE80 (-1.5). Same operands, both unsigned -> raw 0x17E8000>>8=0x17E80, clamped to 0xFFFF, ovf=1.
- 0x7F00 x 0x7F00 signed -> 0x7FFF, ovf=1. 0x8000 x 0x7F00 signed -> 0x8000, ovf=1.
- Rounding: 0x0001 x 0x0080 signed -> 0x0001. 0x0001 x 0x007F -> 0x0000.
- Backpressure: stream 6 back-to-back ops with out_ready=0 for cycles 4..9 -> in_ready drops after 3 held results, then all 6 emerge in order, none dropped or duplicated. Repeat with ce=0 pulses -> identical result sequence.
- reset asserted for 1 cycle with 2 ops in flight -> out_valid=0 next cycle, dout=0, and a following op gives its correct result after 3 cycles.
